macro_io_ctrl: RTL
==================

// Module: macro_io_ctrl
// PURPOSE
//  Parametrised, Wishbone-programmable pad-ring macro for the caravel_mini tile grid.
//  Drives its north/east/west IO banks from software-written registers, or from a
//  walking-one pattern generator with a programmable step divider.
//  Samples bank inputs through 2-flop synchronisers. Exposes a read-only per-instance ID.
// PARAMETERS
//  NUMBER    0             instance ID; reset pattern is 1<<(NUMBER % bank width)
//  N_NORTH   10            north bank width, 1..32
//  N_EAST    14            east bank width, 1..32
//  N_WEST    14            west bank width, 1..32
//  BASE_ADR  32'h3000_0000 decode base; window = BASE_ADR[31:8], 256 B
// PORTS
//  wb_clk_i    in   1        single clock; all logic rising-edge
//  wb_rst_i    in   1        reset, asynchronous, active-high
//  wbs_stb_i   in   1        WB strobe
//  wbs_cyc_i   in   1        WB cycle
//  wbs_we_i    in   1        WB write enable
//  wbs_sel_i   in   4        WB byte lane selects
//  wbs_adr_i   in   32       WB byte address
//  wbs_dat_i   in   32       WB write data
//  wbs_ack_o   out  1        WB acknowledge
//  wbs_dat_o   out  32       WB read data
//  IO_north_i  in   N_NORTH  north pad inputs; likewise IO_east_i/N_EAST, IO_west_i/N_WEST
//  IO_north_o  out  N_NORTH  north pad outputs; likewise IO_east_o, IO_west_o
//  IO_north_oe out  N_NORTH  north output enables (1=drive); likewise IO_east_oe, IO_west_oe
// BEHAVIOUR
//  Register map (offset = adr[7:0]; word aligned; bits above bank width read 0 and ignore writes):
//   0x00 ID    RO   {24'h0, NUMBER[7:0]}
//   0x04 CTRL  RW   [0] RUN, [1] MODE (0 = static, 1 = walk); reset 0
//   0x08/0x0C/0x10  N/E/W_OUT  RW; reset 1<<(NUMBER % width)
//   0x14/0x18/0x1C  N/E/W_OE   RW; reset all ones
//   0x20/0x24/0x28  N/E/W_IN   RO; synchronised inputs; reset 0
//   0x2C DIV   RW   [15:0]; reset 0; walk step every DIV+1 cycles
//   other offsets in window: ack, read 0, writes ignored
//  IO_*_o = *_OUT; IO_*_oe = *_OE; no combinational path from WB inputs to pads.
//  Wishbone:
//   - hit = stb & cyc & (adr[31:8] == BASE_ADR[31:8])
//   - ack registered: ack <= hit & ~ack (1-cycle pulse, 1 cycle latency)
//   - held stb gives ack every other cycle
//   - write performed in the cycle ack is set, per-byte via sel
//   - dat_o registered with ack; 0 when ack is low
//   - no hit -> never ack, dat_o = 0
//  Inputs: 2-flop synchroniser per bit, then the IN register; pad edge visible on read after 3 clocks.
//  Walk generator:
//   - 16-bit tick counter runs while RUN & MODE; tick when cnt == DIV, then cnt <= 0
//   - on tick, each *_OUT rotates left by 1 within its width (MSB wraps to bit 0)
//   - width-1 bank: rotate is no-op
//   - RUN=0 or MODE=0: counter cleared, OUT held
//   - write to CTRL or DIV clears counter
//  Simultaneous WB write to an OUT reg and tick: write wins for that register; counter still wraps.
//  OUT = 0 while walking stays 0 (no re-seed).
//  Reset asserted mid-operation: all regs, counter, sync flops, ack to reset values immediately (async).
//  Reset deassertion: internally synchronised (2-flop) before releasing state.
// TESTING
//  1 Reset, NUMBER=3 -> IO_east_o=14'h0008, IO_north_o=10'h008, all OE ones, ack=0; read 0x00 -> 32'h3.
//  2 Write 0x0C=32'hFFFF_ABCD, sel=4'b0011 -> IO_east_o=14'h2BCD one cycle after ack; read back 0x2BCD.
//  3 CTRL=3, DIV=2, N_OUT=10'h200 -> N_OUT 10'h001 after 3 cycles, then 10'h002 after 3 more.
//  4 Drive IO_west_i=14'h1234 -> read 0x28 = 0x1234 no earlier than 3 clocks after the change.
//  5 Read adr 0x3000_0100 -> no ack over 10 cycles.
//  6 Read 0x3000_0040 -> ack, dat 0.
//  7 Held stb -> acks alternate.
//  8 Reset pulse mid-walk -> outputs return to reset pattern, counter 0.

Source files
------------

// File: rtl/macro_io_ctrl.sv
// -----------------------------------------------------------------------------
// macro_io_ctrl
//
// Wishbone-programmable pad-ring macro. Three IO banks (north/east/west) are
// driven from software-written OUT/OE registers. Optionally, a walking-one
// generator rotates every OUT register left by one bit each DIV+1 cycles.
// Bank inputs pass through 2-flop synchronisers into read-only IN registers.
// A read-only ID register returns the instance NUMBER.
//
// Ports
//   wb_clk_i            single rising-edge clock
//   wb_rst_i            asynchronous active-high reset (release is synchronised)
//   wbs_stb_i/cyc_i     Wishbone strobe / cycle
//   wbs_we_i            write enable
//   wbs_sel_i[3:0]      byte lane selects
//   wbs_adr_i[31:0]     byte address; window = BASE_ADR[31:8], 256 B
//   wbs_dat_i[31:0]     write data
//   wbs_ack_o           registered one-cycle acknowledge
//   wbs_dat_o[31:0]     registered read data, 0 whenever ack is low
//   IO_<bank>_i         pad inputs
//   IO_<bank>_o         pad outputs  (= <bank>_OUT register)
//   IO_<bank>_oe        pad output enables, 1 = drive (= <bank>_OE register)
//
// Handshake: an access is accepted in the cycle where stb & cyc & address hit
// and ack is currently low; ack rises on that edge for exactly one cycle and
// the write (if any) lands on that same edge. A held strobe therefore gets
// an ack every other cycle.
//
// Register map (offset = adr[7:2] word index)
//   0x00 ID  RO | 0x04 CTRL [0]RUN [1]MODE | 0x08/0C/10 N/E/W_OUT
//   0x14/18/1C N/E/W_OE | 0x20/24/28 N/E/W_IN RO | 0x2C DIV[15:0]
//   Other offsets inside the window ack, read 0, ignore writes.
// -----------------------------------------------------------------------------
module macro_io_ctrl #(
  parameter int          NUMBER   = 0,
  parameter int          N_NORTH  = 10,
  parameter int          N_EAST   = 14,
  parameter int          N_WEST   = 14,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [N_NORTH-1:0] IO_north_i,
  input  logic [N_EAST-1:0]  IO_east_i,
  input  logic [N_WEST-1:0]  IO_west_i,
  output logic [N_NORTH-1:0] IO_north_o,
  output logic [N_EAST-1:0]  IO_east_o,
  output logic [N_WEST-1:0]  IO_west_o,
  output logic [N_NORTH-1:0] IO_north_oe,
  output logic [N_EAST-1:0]  IO_east_oe,
  output logic [N_WEST-1:0]  IO_west_oe
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int NORTH_SH = NUMBER % N_NORTH;
  localparam int EAST_SH  = NUMBER % N_EAST;
  localparam int WEST_SH  = NUMBER % N_WEST;

  localparam logic [N_NORTH-1:0] NORTH_RST = N_NORTH'(1) << NORTH_SH;
  localparam logic [N_EAST-1:0]  EAST_RST  = N_EAST'(1)  << EAST_SH;
  localparam logic [N_WEST-1:0]  WEST_RST  = N_WEST'(1)  << WEST_SH;

  localparam logic [7:0] ID8 = 8'(NUMBER);

  // Word indices (adr[7:2])
  localparam logic [5:0] IDX_ID    = 6'd0;
  localparam logic [5:0] IDX_CTRL  = 6'd1;
  localparam logic [5:0] IDX_N_OUT = 6'd2;
  localparam logic [5:0] IDX_E_OUT = 6'd3;
  localparam logic [5:0] IDX_W_OUT = 6'd4;
  localparam logic [5:0] IDX_N_OE  = 6'd5;
  localparam logic [5:0] IDX_E_OE  = 6'd6;
  localparam logic [5:0] IDX_W_OE  = 6'd7;
  localparam logic [5:0] IDX_N_IN  = 6'd8;
  localparam logic [5:0] IDX_E_IN  = 6'd9;
  localparam logic [5:0] IDX_W_IN  = 6'd10;
  localparam logic [5:0] IDX_DIV   = 6'd11;

  // ---------------------------------------------------------------------------
  // Reset: asserts immediately, releases two clocks after wb_rst_i falls so
  // that every register leaves reset on the same clean edge.
  // ---------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_rst_sync <= 2'b11;
    else          r_rst_sync <= {r_rst_sync[0], 1'b0};
  end

  assign w_rst = r_rst_sync[1];

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic               r_ack;
  logic [31:0]        r_dat;
  logic               r_run;
  logic               r_mode;
  logic [15:0]        r_div;
  logic [15:0]        r_cnt;
  logic [N_NORTH-1:0] r_north_out, r_north_oe, r_north_s1, r_north_s2, r_north_in;
  logic [N_EAST-1:0]  r_east_out,  r_east_oe,  r_east_s1,  r_east_s2,  r_east_in;
  logic [N_WEST-1:0]  r_west_out,  r_west_oe,  r_west_s1,  r_west_s2,  r_west_in;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic        w_hit;
  logic        w_acc;
  logic        w_wr;
  logic [5:0]  w_idx;
  logic [31:0] w_rdata;
  logic [31:0] w_wval;
  logic        w_unused_adr;

  assign w_hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign w_acc = w_hit & ~r_ack;
  assign w_wr  = w_acc & wbs_we_i;
  assign w_idx = wbs_adr_i[7:2];

  // Byte address bits carry no information for word-aligned registers.
  assign w_unused_adr = ^wbs_adr_i[1:0];

  // Read mux: the current value of the addressed register, zero-extended.
  // It doubles as the "old value" for byte-lane write merging.
  always_comb begin
    w_rdata = 32'h0;
    case (w_idx)
      IDX_ID:    w_rdata = {24'h0, ID8};
      IDX_CTRL:  w_rdata = {30'h0, r_mode, r_run};
      IDX_N_OUT: w_rdata = 32'(r_north_out);
      IDX_E_OUT: w_rdata = 32'(r_east_out);
      IDX_W_OUT: w_rdata = 32'(r_west_out);
      IDX_N_OE:  w_rdata = 32'(r_north_oe);
      IDX_E_OE:  w_rdata = 32'(r_east_oe);
      IDX_W_OE:  w_rdata = 32'(r_west_oe);
      IDX_N_IN:  w_rdata = 32'(r_north_in);
      IDX_E_IN:  w_rdata = 32'(r_east_in);
      IDX_W_IN:  w_rdata = 32'(r_west_in);
      IDX_DIV:   w_rdata = {16'h0, r_div};
      default:   w_rdata = 32'h0;
    endcase
  end

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_wval = f_merge(w_rdata, wbs_dat_i, wbs_sel_i);

  logic w_wr_ctrl, w_wr_div;
  logic w_wr_n_out, w_wr_e_out, w_wr_w_out;
  logic w_wr_n_oe,  w_wr_e_oe,  w_wr_w_oe;

  assign w_wr_ctrl  = w_wr & (w_idx == IDX_CTRL);
  assign w_wr_div   = w_wr & (w_idx == IDX_DIV);
  assign w_wr_n_out = w_wr & (w_idx == IDX_N_OUT);
  assign w_wr_e_out = w_wr & (w_idx == IDX_E_OUT);
  assign w_wr_w_out = w_wr & (w_idx == IDX_W_OUT);
  assign w_wr_n_oe  = w_wr & (w_idx == IDX_N_OE);
  assign w_wr_e_oe  = w_wr & (w_idx == IDX_E_OE);
  assign w_wr_w_oe  = w_wr & (w_idx == IDX_W_OE);

  // ---------------------------------------------------------------------------
  // Wishbone ack / read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge w_rst) begin
    if (w_rst) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_acc ? w_rdata : 32'h0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

  // ---------------------------------------------------------------------------
  // Walk generator
  // ---------------------------------------------------------------------------
  logic               w_walk;
  logic               w_tick;
  logic [N_NORTH-1:0] w_north_rot;
  logic [N_EAST-1:0]  w_east_rot;
  logic [N_WEST-1:0]  w_west_rot;

  assign w_walk = r_run & r_mode;
  assign w_tick = w_walk & (r_cnt == r_div);

  // Rotate-left written as a shift pair so a width-1 bank degenerates to a
  // no-op: (x << 1) truncates to 0 and (x >> 0) is x itself.
  assign w_north_rot = (r_north_out << 1) | (r_north_out >> (N_NORTH - 1));
  assign w_east_rot  = (r_east_out  << 1) | (r_east_out  >> (N_EAST  - 1));
  assign w_west_rot  = (r_west_out  << 1) | (r_west_out  >> (N_WEST  - 1));

  always_ff @(posedge wb_clk_i or posedge w_rst) begin
    if (w_rst) begin
      r_cnt <= 16'h0;
    end else if (!w_walk || w_wr_ctrl || w_wr_div) begin
      r_cnt <= 16'h0;
    end else if (r_cnt == r_div) begin
      r_cnt <= 16'h0;
    end else begin
      r_cnt <= r_cnt + 16'h1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control and OE registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge w_rst) begin
    if (w_rst) begin
      r_run      <= 1'b0;
      r_mode     <= 1'b0;
      r_div      <= 16'h0;
      r_north_oe <= '1;
      r_east_oe  <= '1;
      r_west_oe  <= '1;
    end else begin
      if (w_wr_ctrl) begin
        r_run  <= w_wval[0];
        r_mode <= w_wval[1];
      end
      if (w_wr_div)  r_div      <= w_wval[15:0];
      if (w_wr_n_oe) r_north_oe <= w_wval[N_NORTH-1:0];
      if (w_wr_e_oe) r_east_oe  <= w_wval[N_EAST-1:0];
      if (w_wr_w_oe) r_west_oe  <= w_wval[N_WEST-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // OUT registers: a bus write takes priority over a walk step on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge w_rst) begin
    if (w_rst) begin
      r_north_out <= NORTH_RST;
      r_east_out  <= EAST_RST;
      r_west_out  <= WEST_RST;
    end else begin
      if (w_wr_n_out)  r_north_out <= w_wval[N_NORTH-1:0];
      else if (w_tick) r_north_out <= w_north_rot;

      if (w_wr_e_out)  r_east_out  <= w_wval[N_EAST-1:0];
      else if (w_tick) r_east_out  <= w_east_rot;

      if (w_wr_w_out)  r_west_out  <= w_wval[N_WEST-1:0];
      else if (w_tick) r_west_out  <= w_west_rot;
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchronisers: two metastability flops, then the readable IN stage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge w_rst) begin
    if (w_rst) begin
      r_north_s1 <= '0;
      r_north_s2 <= '0;
      r_north_in <= '0;
      r_east_s1  <= '0;
      r_east_s2  <= '0;
      r_east_in  <= '0;
      r_west_s1  <= '0;
      r_west_s2  <= '0;
      r_west_in  <= '0;
    end else begin
      r_north_s1 <= IO_north_i;
      r_north_s2 <= r_north_s1;
      r_north_in <= r_north_s2;
      r_east_s1  <= IO_east_i;
      r_east_s2  <= r_east_s1;
      r_east_in  <= r_east_s2;
      r_west_s1  <= IO_west_i;
      r_west_s2  <= r_west_s1;
      r_west_in  <= r_west_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // Pads come straight from registers only.
  // ---------------------------------------------------------------------------
  assign IO_north_o  = r_north_out;
  assign IO_east_o   = r_east_out;
  assign IO_west_o   = r_west_out;
  assign IO_north_oe = r_north_oe;
  assign IO_east_oe  = r_east_oe;
  assign IO_west_oe  = r_west_oe;

endmodule
